// File: rtl/tcdm_prio_scheduler_pkg.sv
// Shared definitions for the TCDM priority scheduler: FSM state encoding,
// config register indices and CTRL register bit positions.
package tcdm_prio_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_NORMAL  = 2'd0,
      ST_BOOST   = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_e;

   localparam logic [1:0] REG_CTRL      = 2'd0;
   localparam logic [1:0] REG_MAX_STALL = 2'd1;
   localparam logic [1:0] REG_BOOST_LEN = 2'd2;
   localparam logic [1:0] REG_STATS     = 2'd3;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_DFLT_BIT = 1;
   localparam int CTRL_POL_LSB  = 2;

endpackage

// File: rtl/tcdm_prio_scheduler_if.sv
// Config bus of the TCDM priority scheduler: single-cycle request with grant,
// response (valid + read data) one cycle later.
interface tcdm_prio_scheduler_if;

   logic        cfg_req_i;
   logic        cfg_wen_i;
   logic [1:0]  cfg_addr_i;
   logic [31:0] cfg_wdata_i;
   logic        cfg_gnt_o;
   logic        cfg_r_valid_o;
   logic [31:0] cfg_r_rdata_o;

   modport master (
      output cfg_req_i, cfg_wen_i, cfg_addr_i, cfg_wdata_i,
      input  cfg_gnt_o, cfg_r_valid_o, cfg_r_rdata_o
   );

   modport slave (
      input  cfg_req_i, cfg_wen_i, cfg_addr_i, cfg_wdata_i,
      output cfg_gnt_o, cfg_r_valid_o, cfg_r_rdata_o
   );

endinterface

// File: rtl/tcdm_prio_scheduler_regs.sv
// Register file and config port of the TCDM priority scheduler.
// Optional feature: define TCDM_PRIO_STATS_EN to implement the STATS boost
// event counter at address 3; without it address 3 reads 0 and ignores writes.
module tcdm_prio_scheduler_regs
   import tcdm_prio_scheduler_pkg::*;
#(
   parameter int CntWidth   = 8,
   parameter int StatsWidth = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   tcdm_prio_scheduler_if.slave cfg,
   input  logic                boost_event,
   output logic                enable,
   output logic                default_hwpe_prio,
   output logic [1:0]          arb_policy,
   output logic [CntWidth-1:0] max_stall,
   output logic [CntWidth-1:0] boost_len,
   output logic                disable_wr
);

   logic        wr_en;
   logic        rd_en;
   logic [31:0] rd_value;
   logic        unused_wdata;

   assign wr_en        = cfg.cfg_req_i & ~cfg.cfg_wen_i;
   assign rd_en        = cfg.cfg_req_i &  cfg.cfg_wen_i;
   assign cfg.cfg_gnt_o = cfg.cfg_req_i;
   // A CTRL write that clears enable aborts any boost in the same cycle.
   assign disable_wr   = wr_en && (cfg.cfg_addr_i == REG_CTRL) && !cfg.cfg_wdata_i[CTRL_EN_BIT];
   assign unused_wdata = ^cfg.cfg_wdata_i;

`ifdef TCDM_PRIO_STATS_EN
   logic [StatsWidth-1:0] stats;

   // Boost event counter; a clearing write wins over a coincident event.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stats <= '0;
      end else if (wr_en && (cfg.cfg_addr_i == REG_STATS)) begin
         stats <= '0;
      end else if (boost_event && (stats != '1)) begin
         stats <= stats + 1'b1;
      end
   end
`else
   logic unused_event;
   assign unused_event = boost_event;
`endif

   // Configuration register writes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         enable            <= 1'b0;
         default_hwpe_prio <= 1'b0;
         arb_policy        <= 2'd0;
         max_stall         <= '0;
         boost_len         <= '0;
      end else if (wr_en) begin
         case (cfg.cfg_addr_i)
            REG_CTRL: begin
               enable            <= cfg.cfg_wdata_i[CTRL_EN_BIT];
               default_hwpe_prio <= cfg.cfg_wdata_i[CTRL_DFLT_BIT];
               arb_policy        <= cfg.cfg_wdata_i[CTRL_POL_LSB +: 2];
            end
            REG_MAX_STALL: max_stall <= cfg.cfg_wdata_i[CntWidth-1:0];
            REG_BOOST_LEN: boost_len <= cfg.cfg_wdata_i[CntWidth-1:0];
            default: ;
         endcase
      end
   end

   // Read mux; unimplemented bits read as zero.
   always_comb begin
      rd_value = '0;
      case (cfg.cfg_addr_i)
         REG_CTRL: begin
            rd_value[CTRL_EN_BIT]          = enable;
            rd_value[CTRL_DFLT_BIT]        = default_hwpe_prio;
            rd_value[CTRL_POL_LSB +: 2]    = arb_policy;
         end
         REG_MAX_STALL: rd_value[CntWidth-1:0] = max_stall;
         REG_BOOST_LEN: rd_value[CntWidth-1:0] = boost_len;
`ifdef TCDM_PRIO_STATS_EN
         REG_STATS:     rd_value[StatsWidth-1:0] = stats;
`endif
         default: ;
      endcase
   end

   // Response one cycle after each granted access; writes answer with 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg.cfg_r_valid_o <= 1'b0;
         cfg.cfg_r_rdata_o <= '0;
      end else begin
         cfg.cfg_r_valid_o <= cfg.cfg_req_i;
         cfg.cfg_r_rdata_o <= rd_en ? rd_value : '0;
      end
   end

endmodule

// File: rtl/tcdm_prio_scheduler.sv
// TCDM priority scheduler: watches how long the low-priority branch stalls
// and temporarily inverts the HWPE/core priority to avoid starvation.
// Optional feature: TCDM_PRIO_STATS_EN enables the STATS boost counter.
module tcdm_prio_scheduler
   import tcdm_prio_scheduler_pkg::*;
#(
   parameter int CntWidth   = 8,
   parameter int StatsWidth = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 core_req_i,
   input  logic                 core_stall_i,
   input  logic                 hwpe_req_i,
   input  logic                 hwpe_stall_i,
   tcdm_prio_scheduler_if.slave cfg,
   output logic [1:0]           arb_policy_o,
   output logic                 hwpe_prio_o,
   output logic                 invert_prio_o
);

   logic                enable;
   logic                default_hwpe_prio;
   logic [1:0]          arb_policy;
   logic [CntWidth-1:0] max_stall;
   logic [CntWidth-1:0] boost_len;
   logic                disable_wr;
   logic                boost_event;

   state_e              state, state_next;
   logic [CntWidth-1:0] cnt, cnt_next;
   logic [CntWidth:0]   cnt_inc;
   logic [CntWidth-1:0] boost_len_eff;
   logic                lp_stall;
   logic                unused_req;

   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   tcdm_prio_scheduler_regs #(
      .CntWidth   (CntWidth),
      .StatsWidth (StatsWidth)
   ) u_regs (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .cfg               (cfg),
      .boost_event       (boost_event),
      .enable            (enable),
      .default_hwpe_prio (default_hwpe_prio),
      .arb_policy        (arb_policy),
      .max_stall         (max_stall),
      .boost_len         (boost_len),
      .disable_wr        (disable_wr)
   );

   // The request lines only qualify the stall lines and are not needed here.
   assign unused_req    = core_req_i ^ hwpe_req_i;
   // The branch without default priority is the one that can starve.
   assign lp_stall      = default_hwpe_prio ? core_stall_i : hwpe_stall_i;
   // Extra bit so the compare still works once the counter saturates.
   assign cnt_inc       = {1'b0, cnt} + 1'b1;
   assign boost_len_eff = (boost_len == '0) ? CntWidth'(1) : boost_len;

   // Next-state and counter logic; an enable-clearing write overrides all.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      boost_event = 1'b0;
      case (state)
         ST_NORMAL: begin
            if (!lp_stall) begin
               cnt_next = '0;
            end else if (enable && (max_stall != '0) && (cnt_inc >= {1'b0, max_stall})) begin
               state_next  = ST_BOOST;
               cnt_next    = '0;
               boost_event = 1'b1;
            end else begin
               cnt_next = sat_inc(cnt);
            end
         end
         ST_BOOST: begin
            if (cnt_inc >= {1'b0, boost_len_eff}) begin
               state_next = ST_HOLDOFF;
               cnt_next   = '0;
            end else begin
               cnt_next = sat_inc(cnt);
            end
         end
         ST_HOLDOFF: begin
            state_next = ST_NORMAL;
            cnt_next   = '0;
         end
         default: begin
            state_next = ST_NORMAL;
            cnt_next   = '0;
         end
      endcase
      if (disable_wr) begin
         state_next  = ST_NORMAL;
         cnt_next    = '0;
         boost_event = 1'b0;
      end
   end

   // State, counter and registered interconnect control outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= ST_NORMAL;
         cnt           <= '0;
         invert_prio_o <= 1'b0;
         hwpe_prio_o   <= 1'b0;
         arb_policy_o  <= 2'd0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         invert_prio_o <= (state == ST_BOOST);
         hwpe_prio_o   <= (state == ST_BOOST) ? ~default_hwpe_prio : default_hwpe_prio;
         arb_policy_o  <= arb_policy;
      end
   end

endmodule
